// File: rtl/scheduler_tick_ctrl_if.sv
// Packet-source and scheduler-control signals of scheduler_tick_ctrl.
// The master side drives tick and the packet sources; the slave side is the controller.
interface scheduler_tick_ctrl_if #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned PKT_W     = 12
);
   logic                       tick;
   logic [NUM_PORTS-1:0]       in_valid;
   logic [NUM_PORTS*PKT_W-1:0] in_packet;
   logic [NUM_PORTS-1:0]       in_ready;
   logic                       sched_wen;
   logic [PKT_W-1:0]           sched_packet;
   logic                       sched_set;
   logic                       sched_clr;
   logic                       sched_clr_avr;
   logic                       sched_clr_spiked;
   logic                       busy;
   logic                       frame_done;
   logic                       tick_overrun;

   modport master (
      output tick, in_valid, in_packet,
      input  in_ready, sched_wen, sched_packet, sched_set, sched_clr, sched_clr_avr,
             sched_clr_spiked, busy, frame_done, tick_overrun
   );

   modport slave (
      input  tick, in_valid, in_packet,
      output in_ready, sched_wen, sched_packet, sched_set, sched_clr, sched_clr_avr,
             sched_clr_spiked, busy, frame_done, tick_overrun
   );
endinterface

// File: rtl/scheduler_tick_ctrl.sv
// Axon-scheduler front end: round-robin packet arbitration while idle, and a
// per-tick flush -> set -> hold -> clr (-> frame clear) control sequence.
module scheduler_tick_ctrl #(
   parameter int unsigned NUM_PORTS       = 4,
   parameter int unsigned PKT_W           = 12,
   parameter int unsigned TICKS_PER_FRAME = 16,
   parameter int unsigned FLUSH_CYCLES    = 2,
   parameter int unsigned AXON_HOLD       = 4,
   parameter bit          CLR_SPIKED_TICK = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   scheduler_tick_ctrl_if.slave bus
);
   localparam int unsigned PtrW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned FcW    = $clog2(TICKS_PER_FRAME + 1);
   localparam int unsigned MaxCyc = (FLUSH_CYCLES > AXON_HOLD) ? FLUSH_CYCLES : AXON_HOLD;
   localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

   typedef enum logic [2:0] {StIdle, StFlush, StSet, StHold, StClr, StFrame} state_e;

   state_e            r_state;
   logic [PtrW-1:0]   r_rr;
   logic [FcW-1:0]    r_frame_cnt;
   logic [CntW-1:0]   r_cnt;
   logic              r_wen;
   logic [PKT_W-1:0]  r_packet;
   logic              r_set;
   logic              r_clr;
   logic              r_clr_avr;
   logic              r_clr_spiked;
   logic              r_busy;
   logic              r_frame_done;
   logic              r_overrun;

   logic [NUM_PORTS-1:0] w_grant;
   logic                 w_any;
   logic [PtrW-1:0]      w_gidx;
   logic [PtrW-1:0]      w_cand;
   logic [PKT_W-1:0]     w_pkt;

   // Search starts at the rr pointer; the tick cycle itself never grants.
   always_comb begin
      w_grant = '0;
      w_any   = 1'b0;
      w_gidx  = '0;
      w_cand  = '0;
      w_pkt   = '0;
      if (r_state == StIdle && !bus.tick) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand = PtrW'((int'(r_rr) + i) % NUM_PORTS);
            if (!w_any && bus.in_valid[w_cand]) begin
               w_any  = 1'b1;
               w_gidx = w_cand;
            end
         end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (w_any && w_gidx == PtrW'(p)) begin
            w_grant[p] = 1'b1;
            w_pkt      = bus.in_packet[p*PKT_W +: PKT_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_rr         <= '0;
         r_frame_cnt  <= '0;
         r_cnt        <= '0;
         r_wen        <= 1'b0;
         r_packet     <= '0;
         r_set        <= 1'b0;
         r_clr        <= 1'b0;
         r_clr_avr    <= 1'b0;
         r_clr_spiked <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_wen        <= 1'b0;
         r_set        <= 1'b0;
         r_clr        <= 1'b0;
         r_clr_avr    <= 1'b0;
         r_clr_spiked <= 1'b0;
         r_frame_done <= 1'b0;
         if (bus.tick && r_state != StIdle) r_overrun <= 1'b1;
         case (r_state)
            StIdle: begin
               if (bus.tick) begin
                  r_state <= StFlush;
                  r_busy  <= 1'b1;
                  r_cnt   <= CntW'(FLUSH_CYCLES - 1);
               end else if (w_any) begin
                  r_wen    <= 1'b1;
                  r_packet <= w_pkt;
                  r_rr     <= PtrW'((int'(w_gidx) + 1) % NUM_PORTS);
               end
            end
            StFlush: begin
               if (r_cnt == '0) begin
                  r_state <= StSet;
                  r_set   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            StSet: begin
               r_state     <= StHold;
               r_cnt       <= CntW'(AXON_HOLD - 1);
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            StHold: begin
               if (r_cnt == '0) begin
                  r_state      <= StClr;
                  r_clr        <= 1'b1;
                  r_clr_spiked <= CLR_SPIKED_TICK;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            StClr: begin
               if (r_frame_cnt == FcW'(TICKS_PER_FRAME)) begin
                  r_state      <= StFrame;
                  r_clr_avr    <= 1'b1;
                  r_clr_spiked <= 1'b1;
                  r_frame_done <= 1'b1;
               end else begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end
            end
            StFrame: begin
               r_frame_cnt <= '0;
               r_state     <= StIdle;
               r_busy      <= 1'b0;
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready         = w_grant;
   assign bus.sched_wen        = r_wen;
   assign bus.sched_packet     = r_packet;
   assign bus.sched_set        = r_set;
   assign bus.sched_clr        = r_clr;
   assign bus.sched_clr_avr    = r_clr_avr;
   assign bus.sched_clr_spiked = r_clr_spiked;
   assign bus.busy             = r_busy;
   assign bus.frame_done       = r_frame_done;
   assign bus.tick_overrun     = r_overrun;
endmodule

// File: tb/tb_scheduler_tick_ctrl.sv
// Bench for scheduler_tick_ctrl: directed scenarios plus random traffic, all checked
// every cycle against a cycle-offset reference model of the tick sequence.
module tb_scheduler_tick_ctrl;
   localparam int NP  = 4;
   localparam int PW  = 12;
   localparam int TPF = 16;
   localparam int F   = 2;
   localparam int H   = 4;
   localparam bit CSP = 1'b0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   scheduler_tick_ctrl_if #(.NUM_PORTS(NP), .PKT_W(PW)) bus ();

   scheduler_tick_ctrl #(
      .NUM_PORTS(NP), .PKT_W(PW), .TICKS_PER_FRAME(TPF),
      .FLUSH_CYCLES(F), .AXON_HOLD(H), .CLR_SPIKED_TICK(CSP)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: a sequence is a cycle offset m_rel from its accepted tick.
   bit          m_active;
   int          m_rel;
   bit          m_frame;
   int          m_fcnt;
   int          m_rr;
   bit          m_wen;
   logic [PW-1:0] m_pkt;
   bit          m_ovr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0; m_rel = 0; m_frame = 1'b0; m_fcnt = 0;
      m_rr = 0; m_wen = 1'b0; m_pkt = '0; m_ovr = 1'b0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      bus.tick = 1'b0; bus.in_valid = '0; bus.in_packet = '0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready",   32'(bus.in_ready), 0);
      check_eq("rst_wen",     32'(bus.sched_wen), 0);
      check_eq("rst_pkt",     32'(bus.sched_packet), 0);
      check_eq("rst_ctl",     32'({bus.sched_set, bus.sched_clr, bus.sched_clr_avr,
                                   bus.sched_clr_spiked}), 0);
      check_eq("rst_busy",    32'(bus.busy), 0);
      check_eq("rst_fdone",   32'(bus.frame_done), 0);
      check_eq("rst_overrun", 32'(bus.tick_overrun), 0);
      rst = 1'b0;
      model_reset();
      cyc = 0;
   endtask

   // Called at a falling edge: drive, check this cycle, advance the model across the edge.
   task automatic step(input bit t, input logic [NP-1:0] v, input logic [NP*PW-1:0] pk);
      int g;
      logic [NP-1:0] exp_ready;
      bit set_e, clr_e, fr_e, spk_e;
      bus.tick = t; bus.in_valid = v; bus.in_packet = pk;
      #1;
      g = -1;
      if (!m_active && !t)
         for (int i = 0; i < NP; i++) begin
            int c;
            c = (m_rr + i) % NP;
            if (g < 0 && v[c]) g = c;
         end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      set_e = m_active && m_rel == F + 1;
      clr_e = m_active && m_rel == F + H + 2;
      fr_e  = m_active && m_frame && m_rel == F + H + 3;
      spk_e = fr_e || (CSP && clr_e);
      check_eq("in_ready",   32'(bus.in_ready), 32'(exp_ready));
      check_eq("wen",        32'(bus.sched_wen), 32'(m_wen));
      check_eq("packet",     32'(bus.sched_packet), 32'(m_pkt));
      check_eq("set",        32'(bus.sched_set), 32'(set_e));
      check_eq("clr",        32'(bus.sched_clr), 32'(clr_e));
      check_eq("clr_avr",    32'(bus.sched_clr_avr), 32'(fr_e));
      check_eq("clr_spiked", 32'(bus.sched_clr_spiked), 32'(spk_e));
      check_eq("frame_done", 32'(bus.frame_done), 32'(fr_e));
      check_eq("busy",       32'(bus.busy), 32'(m_active));
      check_eq("overrun",    32'(bus.tick_overrun), 32'(m_ovr));
      m_wen = (g >= 0);
      if (g >= 0) begin
         m_pkt = pk[g*PW +: PW];
         m_rr  = (g + 1) % NP;
      end
      if (t && m_active) m_ovr = 1'b1;
      if (t && !m_active) begin
         m_fcnt++;
         m_frame = (m_fcnt == TPF);
         if (m_frame) m_fcnt = 0;
         m_active = 1'b1;
         m_rel = 1;
      end else if (m_active) begin
         m_rel++;
         if (m_rel > F + H + 2 + int'(m_frame)) m_active = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   function automatic logic [NP*PW-1:0] rnd_pk();
      logic [63:0] tmp;
      tmp = {$urandom(), $urandom()};
      return tmp[NP*PW-1:0];
   endfunction

   initial begin
      model_reset();
      @(negedge clk);
      do_reset(3);
      repeat (3) step(1'b0, '0, rnd_pk());
      // Round-robin with every port requesting.
      repeat (8) step(1'b0, '1, rnd_pk());
      // Tick collides with a port-2 request; port 2 waits for the sequence.
      step(1'b1, 4'b0100, rnd_pk());
      repeat (11) step(1'b0, 4'b0100, rnd_pk());
      // Enough spaced ticks to cross a frame boundary and start the next frame.
      for (int k = 0; k < TPF + 2; k++) begin
         step(1'b1, 4'($urandom()), rnd_pk());
         repeat (11) step(1'b0, 4'($urandom()), rnd_pk());
      end
      // Random traffic and ticks, overruns included.
      for (int k = 0; k < 1500; k++)
         step($urandom_range(0, 11) == 0, 4'($urandom()), rnd_pk());
      do_reset(2);
      // Tick during HOLD overruns; only reset clears the flag.
      step(1'b1, '0, rnd_pk());
      repeat (5) step(1'b0, '0, rnd_pk());
      step(1'b1, '0, rnd_pk());
      repeat (20) step(1'b0, 4'($urandom()), rnd_pk());
      // Reset mid-sequence aborts without set/clr.
      step(1'b1, '0, rnd_pk());
      step(1'b0, '0, rnd_pk());
      do_reset(1);
      repeat (12) step(1'b0, 4'($urandom()), rnd_pk());
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
